// File: rtl/regs_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Source identifiers, age-counter width and the hard-wired zero register.
package regs_wb_arbiter_pkg;

  localparam int         AGE_W  = 4;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_PIPE = 2'd1,
    REQ_LD   = 2'd2,
    REQ_MD   = 2'd3
  } req_e;

endpackage

// File: rtl/regs_wb_arbiter_if.sv
// Writeback, issue-check and register-file write-port signals of the arbiter.
// The slave modport is the arbiter side; master is the surrounding core.
interface regs_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            i_pipe_vld;
  logic [4:0]      i_pipe_rd;
  logic [XLEN-1:0] i_pipe_dat;
  logic            o_pipe_rdy;

  logic            i_ld_vld;
  logic [4:0]      i_ld_rd;
  logic [XLEN-1:0] i_ld_dat;
  logic            o_ld_rdy;

  logic            i_md_vld;
  logic [4:0]      i_md_rd;
  logic [XLEN-1:0] i_md_dat;
  logic            o_md_rdy;

  logic            i_iss_vld;
  logic            i_iss_long;
  logic [4:0]      i_iss_rs1;
  logic [4:0]      i_iss_rs2;
  logic [4:0]      i_iss_rd;
  logic            o_iss_hazard;

  logic            o_we;
  logic [4:0]      o_addr_wr;
  logic [XLEN-1:0] o_dat_wr;

  modport slave (
    input  i_pipe_vld, i_pipe_rd, i_pipe_dat,
    output o_pipe_rdy,
    input  i_ld_vld, i_ld_rd, i_ld_dat,
    output o_ld_rdy,
    input  i_md_vld, i_md_rd, i_md_dat,
    output o_md_rdy,
    input  i_iss_vld, i_iss_long, i_iss_rs1, i_iss_rs2, i_iss_rd,
    output o_iss_hazard,
    output o_we, o_addr_wr, o_dat_wr
  );

  modport master (
    output i_pipe_vld, i_pipe_rd, i_pipe_dat,
    input  o_pipe_rdy,
    output i_ld_vld, i_ld_rd, i_ld_dat,
    input  o_ld_rdy,
    output i_md_vld, i_md_rd, i_md_dat,
    input  o_md_rdy,
    output i_iss_vld, i_iss_long, i_iss_rs1, i_iss_rs2, i_iss_rd,
    input  o_iss_hazard,
    input  o_we, o_addr_wr, o_dat_wr
  );

endinterface

// File: rtl/regs_wb_arbiter_rr_arb2.sv
// Two-way round-robin picker between the load unit (bit 0) and mul/div (bit 1).
// The pointer moves to the other source after every slow grant; reset favours load.
module regs_wb_arbiter_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

  logic ptr_q, ptr_d;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = ptr_q ? 2'b10 : 2'b01;
    ptr_d = ptr_q;
    if (i_adv) ptr_d = o_gnt[0];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter: pipeline / load / mul-div writeback sharing,
// starvation aging for slow sources and a pending scoreboard for issue hazards.
module regs_wb_arbiter
  import regs_wb_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  regs_wb_arbiter_if.slave   bus
);

  logic [31:0]      pend_q, pend_d;
  logic [AGE_W-1:0] age_q, age_d;

  logic            slow_any, starved, slow_taken;
  logic [1:0]      slow_gnt;
  req_e            grant;
  reg_idx_t        wr_rd;
  logic [XLEN-1:0] wr_dat;
  logic            hazard;
  logic            set_en, clr_en;

  assign slow_any   = bus.i_ld_vld | bus.i_md_vld;
  assign starved    = slow_any && (age_q >= AGE_W'(STARVE_MAX));
  assign slow_taken = (grant == REQ_LD) || (grant == REQ_MD);

  regs_wb_arbiter_rr_arb2 u_rr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   ({bus.i_md_vld, bus.i_ld_vld}),
    .i_adv   (slow_taken),
    .o_gnt   (slow_gnt)
  );

  // An aged slow request outranks the pipeline; otherwise the pipeline goes first.
  always_comb begin
    grant = REQ_NONE;
    if (starved)             grant = slow_gnt[0] ? REQ_LD : REQ_MD;
    else if (bus.i_pipe_vld) grant = REQ_PIPE;
    else if (slow_gnt[0])    grant = REQ_LD;
    else if (slow_gnt[1])    grant = REQ_MD;
    if (!i_rst_n)            grant = REQ_NONE;
  end

  always_comb begin
    wr_rd  = REG_X0;
    wr_dat = '0;
    unique case (grant)
      REQ_PIPE: begin wr_rd = bus.i_pipe_rd; wr_dat = bus.i_pipe_dat; end
      REQ_LD:   begin wr_rd = bus.i_ld_rd;   wr_dat = bus.i_ld_dat;   end
      REQ_MD:   begin wr_rd = bus.i_md_rd;   wr_dat = bus.i_md_dat;   end
      default:  ;
    endcase
  end

  assign bus.o_pipe_rdy = (grant == REQ_PIPE);
  assign bus.o_ld_rdy   = (grant == REQ_LD);
  assign bus.o_md_rdy   = (grant == REQ_MD);
  assign bus.o_we       = (grant != REQ_NONE) && (wr_rd != REG_X0);
  assign bus.o_addr_wr  = wr_rd;
  assign bus.o_dat_wr   = wr_dat;

  // Registered pend only: an issue in the clearing cycle still stalls once.
  assign hazard = i_rst_n && bus.i_iss_vld &&
                  (pend_q[bus.i_iss_rs1] | pend_q[bus.i_iss_rs2] | pend_q[bus.i_iss_rd]);
  assign bus.o_iss_hazard = hazard;

  assign set_en = bus.i_iss_vld && bus.i_iss_long && !hazard && (bus.i_iss_rd != REG_X0);
  assign clr_en = slow_taken;

  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[wr_rd]       = 1'b0;
    if (set_en) pend_d[bus.i_iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    age_d = age_q;
    if (!slow_any || slow_taken)       age_d = '0;
    else if (age_q != {AGE_W{1'b1}})   age_d = age_q + 1'b1;
  end

  // NOTE: the 32-bit scoreboard is plain flops, so it is reset directly; no stale hazards survive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= '0;
      age_q  <= '0;
    end else begin
      pend_q <= pend_d;
      age_q  <= age_d;
    end
  end

`ifndef SYNTHESIS
  a_no_set_clr_same_reg: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(set_en && clr_en && (bus.i_iss_rd == wr_rd)));
`endif

endmodule
